// File: rtl/puf_response_collector.sv
// puf_response_collector
//   Datapath stage for the RO PUF control FSM. It counts synchronized rising
//   edges of two ring oscillators and runs the 8-bit reference window counter
//   (refcount) that the FSM watches. On each sr_en strobe it shifts one
//   response bit (cnt_a > cnt_b) into a shift register. On the FSM's done pulse
//   it presents the completed response through a valid/ready handshake.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   ro_a, ro_b          raw ring-oscillator outputs (asynchronous to clk)
//   count_en            enables the RO edge counters
//   count_reset         clears RO counters, sat and refcount (highest priority)
//   ref_en              increments refcount (wraps 255 -> 0)
//   sr_en               compare-and-shift strobe
//   done                one-cycle end-of-run pulse
//   refcount [7:0]      reference window count
//   resp_data           latched response
//   resp_valid          resp_data is valid
//   resp_ready          host accepts the response
//   sat                 sticky: an RO counter saturated in this window
//   overrun             sticky: done arrived while resp_valid was still high
//   resp_mask           (RESP_MASK_EN only) stability mask, handled like resp_data
//
// Build option: define RESP_MASK_EN to add the stability mask path.

module puf_response_collector #(
  parameter int RESP_BITS   = 256,
  parameter int CNT_W       = 16,
  parameter int MASK_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ro_a,
  input  logic                 ro_b,
  input  logic                 count_en,
  input  logic                 count_reset,
  input  logic                 ref_en,
  input  logic                 sr_en,
  input  logic                 done,
  output logic [7:0]           refcount,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 sat,
`ifdef RESP_MASK_EN
  output logic [RESP_BITS-1:0] resp_mask,
`endif
  output logic                 overrun
);

  localparam int BC_W = $clog2(RESP_BITS + 1);
  localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(RESP_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {COLLECT = 1'b0, VALID = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             sync_a_q, sync_b_q;
  logic [CNT_W-1:0]       cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic                   sat_q, sat_d;
  logic [7:0]             refcount_q, refcount_d;
  logic [RESP_BITS-1:0]   shreg_q, shreg_d, shreg_shift;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [RESP_BITS-1:0]   resp_data_q, resp_data_d;
  logic                   overrun_q, overrun_d;
  logic                   edge_a, edge_b, cmp_bit, latch;

  // Two synchronizer stages, third stage only for edge detection.
  assign edge_a  = sync_a_q[1] & ~sync_a_q[2];
  assign edge_b  = sync_b_q[1] & ~sync_b_q[2];
  // Compare uses the counter values registered before this edge, so a
  // simultaneous count_reset still sees the pre-clear counts.
  assign cmp_bit = cnt_a_q > cnt_b_q;
  assign shreg_shift = sr_en ? {shreg_q[RESP_BITS-2:0], cmp_bit} : shreg_q;
  // New data is latched from COLLECT, or from VALID when the handshake
  // completes on the same cycle as done.
  assign latch = done && ((state_q == COLLECT) || resp_ready);

  always_comb begin
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    sat_d      = sat_q;
    refcount_d = refcount_q;
    if (count_reset) begin
      cnt_a_d    = '0;
      cnt_b_d    = '0;
      sat_d      = 1'b0;
      refcount_d = '0;
    end else begin
      if (count_en && edge_a && (cnt_a_q != CNT_MAX)) begin
        cnt_a_d = cnt_a_q + 1'b1;
        if (cnt_a_d == CNT_MAX) sat_d = 1'b1;
      end
      if (count_en && edge_b && (cnt_b_q != CNT_MAX)) begin
        cnt_b_d = cnt_b_q + 1'b1;
        if (cnt_b_d == CNT_MAX) sat_d = 1'b1;
      end
      if (ref_en) refcount_d = refcount_q + 8'd1;
    end
  end

  always_comb begin
    shreg_d   = done ? '0 : shreg_shift;
    bit_cnt_d = bit_cnt_q;
    if (done)
      bit_cnt_d = '0;
    else if (sr_en && (bit_cnt_q != BC_MAX))
      bit_cnt_d = bit_cnt_q + 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (done) state_d = VALID;
      VALID:   if (resp_ready && !done) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Output logic
  always_comb begin
    resp_data_d = resp_data_q;
    overrun_d   = overrun_q;
    if (latch) resp_data_d = shreg_shift;
    if (done && (state_q == VALID) && !resp_ready) overrun_d = 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      sync_a_q    <= '0;
      sync_b_q    <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      sat_q       <= 1'b0;
      refcount_q  <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      resp_data_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_a_q    <= {sync_a_q[1:0], ro_a};
      sync_b_q    <= {sync_b_q[1:0], ro_b};
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      sat_q       <= sat_d;
      refcount_q  <= refcount_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      resp_data_q <= resp_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign refcount   = refcount_q;
  assign resp_data  = resp_data_q;
  assign resp_valid = (state_q == VALID);
  assign sat        = sat_q;
  assign overrun    = overrun_q;

`ifdef RESP_MASK_EN
  localparam logic [CNT_W:0] THRESH = (CNT_W+1)'(MASK_THRESH);

  logic [RESP_BITS-1:0] mshreg_q, mshreg_d, mshreg_shift;
  logic [RESP_BITS-1:0] resp_mask_q, resp_mask_d;
  logic [CNT_W:0]       abs_diff;
  logic                 mask_bit;

  assign abs_diff = (cnt_a_q >= cnt_b_q) ? ({1'b0, cnt_a_q} - {1'b0, cnt_b_q})
                                         : ({1'b0, cnt_b_q} - {1'b0, cnt_a_q});
  // A saturated window makes the difference meaningless, so mark it unstable.
  assign mask_bit     = !sat_q && (abs_diff >= THRESH);
  assign mshreg_shift = sr_en ? {mshreg_q[RESP_BITS-2:0], mask_bit} : mshreg_q;

  always_comb begin
    mshreg_d    = done ? '0 : mshreg_shift;
    resp_mask_d = latch ? mshreg_shift : resp_mask_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mshreg_q    <= '0;
      resp_mask_q <= '0;
    end else begin
      mshreg_q    <= mshreg_d;
      resp_mask_q <= resp_mask_d;
    end
  end

  assign resp_mask = resp_mask_q;
`endif

endmodule

// File: tb/tb_puf_response_collector.sv
module tb_puf_response_collector;

  localparam int RB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ro_a = 1'b0, ro_b = 1'b0;
  logic count_en = 1'b0, count_reset = 1'b0, ref_en = 1'b0;
  logic sr_en = 1'b0, done = 1'b0, resp_ready = 1'b0;

  logic [7:0]    refcount, refcount_s;
  logic [RB-1:0] resp_data, resp_data_s;
  logic          resp_valid, resp_valid_s, sat, sat_s, overrun, overrun_s;
`ifdef RESP_MASK_EN
  logic [RB-1:0] resp_mask, resp_mask_s;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  puf_response_collector #(.RESP_BITS(RB), .CNT_W(16), .MASK_THRESH(4)) dut (
    .clk(clk), .rst(rst), .ro_a(ro_a), .ro_b(ro_b), .count_en(count_en),
    .count_reset(count_reset), .ref_en(ref_en), .sr_en(sr_en), .done(done),
    .refcount(refcount), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .sat(sat),
`ifdef RESP_MASK_EN
    .resp_mask(resp_mask),
`endif
    .overrun(overrun));

  // Narrow-counter instance sharing the same stimulus, for saturation checks.
  puf_response_collector #(.RESP_BITS(RB), .CNT_W(4), .MASK_THRESH(4)) dut_s (
    .clk(clk), .rst(rst), .ro_a(ro_a), .ro_b(ro_b), .count_en(count_en),
    .count_reset(count_reset), .ref_en(ref_en), .sr_en(sr_en), .done(done),
    .refcount(refcount_s), .resp_data(resp_data_s), .resp_valid(resp_valid_s),
    .resp_ready(resp_ready), .sat(sat_s),
`ifdef RESP_MASK_EN
    .resp_mask(resp_mask_s),
`endif
    .overrun(overrun_s));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic shift_n(input int n);
    repeat (n) begin
      sr_en = 1'b1;
      tick();
    end
    sr_en = 1'b0;
  endtask

  // Clear counters, then produce exactly na / nb rising edges and drain the synchronizers.
  task automatic set_counts(input int na, input int nb);
    int mx;
    mx = (na > nb) ? na : nb;
    count_reset = 1'b1;
    tick();
    count_reset = 1'b0;
    if (mx > 0) begin
      count_en = 1'b1;
      for (int i = 0; i < mx; i++) begin
        ro_a = (i < na);
        ro_b = (i < nb);
        repeat (4) tick();
        ro_a = 1'b0;
        ro_b = 1'b0;
        repeat (4) tick();
      end
      repeat (5) tick();
      count_en = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_refcount", 64'(refcount), 64'h0);
    check("rst_valid", 64'(resp_valid), 64'h0);
    check("rst_data", 64'(resp_data), 64'h0);
    check("rst_sat", 64'(sat), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
    rst = 1'b0;

    // 1. refcount wrap and count_reset priority
    ref_en = 1'b1;
    repeat (255) tick();
    check("ref_255", 64'(refcount), 64'hFF);
    tick();
    check("ref_wrap", 64'(refcount), 64'h00);
    repeat (3) tick();
    check("ref_3", 64'(refcount), 64'h03);
    count_reset = 1'b1;
    tick();
    check("ref_clr_prio", 64'(refcount), 64'h00);
    ref_en = 1'b0;
    tick();
    count_reset = 1'b0;
    check("ref_clr_hold", 64'(refcount), 64'h00);

    // 2. frequency compare: a at clk/8, b at clk/10 for 400 cycles
    for (int pass = 0; pass < 3; pass++) begin
      count_reset = 1'b1;
      tick();
      count_reset = 1'b0;
      count_en = 1'b1;
      for (int i = 0; i < 400; i++) begin
        ro_a = (pass == 1) ? ((i % 10) < 5) : ((i % 8) < 4);
        ro_b = (pass == 0) ? ((i % 10) < 5) : ((i % 8) < 4);
        tick();
      end
      ro_a = 1'b0;
      ro_b = 1'b0;
      repeat (5) tick();
      count_en = 1'b0;
      shift_n(1);
      if (pass == 0) begin
        check("cmp_cnt_a", 64'(dut.cnt_a_q), 64'd50);
        check("cmp_cnt_b", 64'(dut.cnt_b_q), 64'd40);
        check("cmp_a_fast", 64'(dut.shreg_q[0]), 64'h1);
      end else if (pass == 1) begin
        check("cmp_b_fast", 64'(dut.shreg_q[0]), 64'h0);
      end else begin
        check("cmp_tie_cnt", 64'(dut.cnt_b_q), 64'd50);
        check("cmp_tie", 64'(dut.shreg_q[0]), 64'h0);
      end
    end

    // 3. response 1,0,1,1,0,0,1,0 with the last bit on the done cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_counts(2, 1); shift_n(1);
    set_counts(0, 0); shift_n(1);
    set_counts(2, 1); shift_n(2);
    set_counts(0, 0); shift_n(2);
    set_counts(2, 1); shift_n(1);
    set_counts(0, 0);
    sr_en = 1'b1; done = 1'b1;
    tick();
    sr_en = 1'b0; done = 1'b0;
    check("run1_data", 64'(resp_data), 64'hB2);
    check("run1_valid", 64'(resp_valid), 64'h1);
    check("run1_overrun", 64'(overrun), 64'h0);

    // 4. overrun: second run completes while B2 is still pending
    set_counts(2, 1);
    shift_n(8);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("ovr_flag", 64'(overrun), 64'h1);
    check("ovr_data_held", 64'(resp_data), 64'hB2);
    check("ovr_valid", 64'(resp_valid), 64'h1);
    check("ovr_shreg_clr", 64'(dut.shreg_q), 64'h0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("hs_valid_low", 64'(resp_valid), 64'h0);
    check("hs_data_held", 64'(resp_data), 64'hB2);
    // partial run: only 3 bits before done
    shift_n(3);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("partial_data", 64'(resp_data), 64'h07);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    shift_n(8);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("run3_data", 64'(resp_data), 64'hFF);
    // collect while VALID; 4th bit shares a cycle with count_reset
    shift_n(3);
    sr_en = 1'b1; count_reset = 1'b1;
    tick();
    sr_en = 1'b0; count_reset = 1'b0;
    check("preclr_cnt", 64'(dut.cnt_a_q), 64'h0);
    shift_n(4);
    done = 1'b1; resp_ready = 1'b1;
    tick();
    done = 1'b0; resp_ready = 1'b0;
    check("done_hs_data", 64'(resp_data), 64'hF0);
    check("done_hs_valid", 64'(resp_valid), 64'h1);
    check("done_hs_ovr", 64'(overrun), 64'h1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // 5. saturation on the 4-bit instance
    set_counts(14, 0);
    check("sat14_cnt", 64'(dut_s.cnt_a_q), 64'd14);
    check("sat14_flag", 64'(sat_s), 64'h0);
    set_counts(20, 0);
    check("sat_cnt", 64'(dut_s.cnt_a_q), 64'd15);
    check("sat_flag", 64'(sat_s), 64'h1);
    check("wide_cnt", 64'(dut.cnt_a_q), 64'd20);
    check("wide_sat", 64'(sat), 64'h0);
    count_reset = 1'b1;
    tick();
    count_reset = 1'b0;
    check("sat_clr_cnt", 64'(dut_s.cnt_a_q), 64'h0);
    check("sat_clr_flag", 64'(sat_s), 64'h0);

    // 6. async reset mid-collection
    set_counts(2, 1);
    ref_en = 1'b1;
    shift_n(3);
    done = 1'b1;
    tick();
    done = 1'b0;
    ref_en = 1'b0;
    check("pre_rst_ref", 64'(refcount), 64'd4);
    check("pre_rst_data", 64'(resp_data), 64'h07);
    shift_n(3);
    rst = 1'b1;
    #1;
    check("rst_mid_ref", 64'(refcount), 64'h0);
    check("rst_mid_data", 64'(resp_data), 64'h0);
    check("rst_mid_valid", 64'(resp_valid), 64'h0);
    check("rst_mid_ovr", 64'(overrun), 64'h0);
    check("rst_mid_shreg", 64'(dut.shreg_q), 64'h0);
    tick();
    rst = 1'b0;
    set_counts(2, 1); shift_n(2);
    set_counts(0, 0); shift_n(2);
    set_counts(2, 1); shift_n(2);
    set_counts(0, 0); shift_n(2);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("post_rst_data", 64'(resp_data), 64'hCC);
    check("post_rst_valid", 64'(resp_valid), 64'h1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // mask threshold: 52 vs 50 unstable, 60 vs 50 stable
    set_counts(52, 50);
    check("m52_cnt", 64'(dut.cnt_a_q), 64'd52);
    shift_n(1);
    set_counts(60, 50);
    check("m60_cnt", 64'(dut.cnt_a_q), 64'd60);
    shift_n(1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("mask_run_data", 64'(resp_data), 64'h03);
`ifdef RESP_MASK_EN
    check("mask_bits", 64'(resp_mask), 64'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
